// File: rtl/lsb_queue.sv
// In-order load/store buffer: CDB wake-up, commit-gated stores, flush recovery.
// Latency: a dispatched ready load drives mem_req one cycle after it reaches the head; its result appears the cycle after mem_ack.
// Backpressure: full stops dispatch unless a pop in the same cycle frees a slot; mem_* are held until mem_ack.
// Ports: disp_* dispatch in; cdb_* operand broadcast in; commit_* store release in;
//   flush mispredict recovery in; mem_* memory request out, mem_ack/mem_rdata in;
//   res_* result/store-ready pulse out to ROB; full out.
module lsb_queue #(
  parameter int DEPTH_LOG = 3,
  parameter int TAG_W     = 5,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_valid,
  input  logic [3:0]        disp_op,
  input  logic [TAG_W-1:0]  disp_q1,
  input  logic [TAG_W-1:0]  disp_q2,
  input  logic [DATA_W-1:0] disp_v1,
  input  logic [DATA_W-1:0] disp_v2,
  input  logic [DATA_W-1:0] disp_imm,
  input  logic [TAG_W-1:0]  disp_tag,
  output logic              full,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              commit_valid,
  input  logic [TAG_W-1:0]  commit_tag,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              res_valid,
  output logic [TAG_W-1:0]  res_tag,
  output logic [DATA_W-1:0] res_data
);
  localparam int DEPTH = 1 << DEPTH_LOG;

  typedef enum logic [2:0] {S_IDLE, S_LD_WAIT, S_ST_COMMIT, S_ST_WAIT, S_DRAIN} state_t;

  state_t               state_q;
  logic [DEPTH_LOG-1:0] head_q, tail_q, head_d, tail_d;
  logic [DEPTH_LOG:0]   count_q, count_d;
  logic                 full_q;
  logic [DEPTH-1:0]     vld_q;
  logic [3:0]           op_q  [DEPTH];
  logic [TAG_W-1:0]     q1_q  [DEPTH];
  logic [TAG_W-1:0]     q2_q  [DEPTH];
  logic [TAG_W-1:0]     tag_q [DEPTH];
  logic [DATA_W-1:0]    v1_q  [DEPTH];
  logic [DATA_W-1:0]    v2_q  [DEPTH];
  logic [DATA_W-1:0]    imm_q [DEPTH];

  logic                 mem_req_q, mem_we_q, res_valid_q;
  logic [1:0]           mem_size_q;
  logic [DATA_W-1:0]    mem_addr_q, mem_wdata_q, res_data_q;
  logic [TAG_W-1:0]     res_tag_q;

  logic                 has_head, cdb_hit, commit_hit, pop, keep, accept;
  logic [DATA_W-1:0]    ld_ext;

  assign full      = full_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign res_valid = res_valid_q;
  assign res_tag   = res_tag_q;
  assign res_data  = res_data_q;

  assign has_head   = (count_q != '0);
  assign cdb_hit    = cdb_valid && (cdb_tag != '0);
  assign commit_hit = commit_valid && (commit_tag == tag_q[head_q]);
  // A load acked in the flush cycle is dropped without popping; the flush clears it.
  assign pop    = mem_ack && ((state_q == S_ST_WAIT) || (state_q == S_LD_WAIT && !flush));
  // Stores already released to memory survive a flush.
  assign keep   = flush && ((state_q == S_ST_WAIT) || (state_q == S_ST_COMMIT && commit_hit));
  // Pop frees a slot in the same cycle, so a full buffer can still accept.
  assign accept = disp_valid && !flush && (!full_q || pop);

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      tail_d  = keep ? head_q + 1'b1 : head_q;
      count_d = {{DEPTH_LOG{1'b0}}, keep};
    end
    if (accept) begin
      tail_d  = tail_q + 1'b1;
      count_d = count_d + 1'b1;
    end
    if (pop) begin
      head_d  = head_q + 1'b1;
      count_d = count_d - 1'b1;
    end
  end

  // Raw memory data extended by the head op (op[2] selects zero-extension).
  always_comb begin
    case (op_q[head_q][1:0])
      2'd0:    ld_ext = op_q[head_q][2] ? {{(DATA_W-8){1'b0}}, mem_rdata[7:0]}
                                        : {{(DATA_W-8){mem_rdata[7]}}, mem_rdata[7:0]};
      2'd1:    ld_ext = op_q[head_q][2] ? {{(DATA_W-16){1'b0}}, mem_rdata[15:0]}
                                        : {{(DATA_W-16){mem_rdata[15]}}, mem_rdata[15:0]};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      vld_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'd0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      res_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i] <= '0; q1_q[i] <= '0; q2_q[i] <= '0; tag_q[i] <= '0;
        v1_q[i] <= '0; v2_q[i] <= '0; imm_q[i] <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      full_q      <= (count_d == (DEPTH_LOG+1)'(DEPTH));
      res_valid_q <= 1'b0;

      // CDB wake-up of waiting operands.
      for (int i = 0; i < DEPTH; i++) begin
        if (vld_q[i] && cdb_hit) begin
          if (q1_q[i] == cdb_tag) begin q1_q[i] <= '0; v1_q[i] <= cdb_data; end
          if (q2_q[i] == cdb_tag) begin q2_q[i] <= '0; v2_q[i] <= cdb_data; end
        end
      end
      if (flush) begin
        for (int i = 0; i < DEPTH; i++)
          if (!(keep && (DEPTH_LOG'(i) == head_q))) vld_q[i] <= 1'b0;
      end
      if (pop) vld_q[head_q] <= 1'b0;
      // Dispatch comes last so it wins when it reuses the slot being popped.
      if (accept) begin
        vld_q[tail_q] <= 1'b1;
        op_q[tail_q]  <= disp_op;
        tag_q[tail_q] <= disp_tag;
        imm_q[tail_q] <= disp_imm;
        if (cdb_hit && disp_q1 == cdb_tag) begin q1_q[tail_q] <= '0; v1_q[tail_q] <= cdb_data; end
        else begin q1_q[tail_q] <= disp_q1; v1_q[tail_q] <= disp_v1; end
        if (cdb_hit && disp_q2 == cdb_tag) begin q2_q[tail_q] <= '0; v2_q[tail_q] <= cdb_data; end
        else begin q2_q[tail_q] <= disp_q2; v2_q[tail_q] <= disp_v2; end
      end

      case (state_q)
        S_IDLE: begin
          if (!flush && has_head) begin
            if (!op_q[head_q][3]) begin
              if (q1_q[head_q] == '0) begin
                mem_req_q  <= 1'b1;
                mem_we_q   <= 1'b0;
                mem_size_q <= op_q[head_q][1:0];
                mem_addr_q <= v1_q[head_q] + imm_q[head_q];
                state_q    <= S_LD_WAIT;
              end
            end else if (q1_q[head_q] == '0 && q2_q[head_q] == '0) begin
              res_valid_q <= 1'b1;
              res_tag_q   <= tag_q[head_q];
              res_data_q  <= '0;
              state_q     <= S_ST_COMMIT;
            end
          end
        end
        S_LD_WAIT: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            if (!flush) begin
              res_valid_q <= 1'b1;
              res_tag_q   <= tag_q[head_q];
              res_data_q  <= ld_ext;
            end
            state_q <= S_IDLE;
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end
        S_ST_COMMIT: begin
          if (commit_hit) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_size_q  <= op_q[head_q][1:0];
            mem_addr_q  <= v1_q[head_q] + imm_q[head_q];
            mem_wdata_q <= v2_q[head_q];
            state_q     <= S_ST_WAIT;
          end else if (flush) begin
            state_q <= S_IDLE;
          end
        end
        S_ST_WAIT: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsb_queue.sv
// Directed bench for lsb_queue: loads, extension, stores, full/wrap, flush, bypass, reset.
module tb_lsb_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        disp_valid;
  logic [3:0]  disp_op;
  logic [4:0]  disp_q1, disp_q2, disp_tag;
  logic [31:0] disp_v1, disp_v2, disp_imm;
  logic        full;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        commit_valid;
  logic [4:0]  commit_tag;
  logic        flush;
  logic        mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        res_valid;
  logic [4:0]  res_tag;
  logic [31:0] res_data;

  int vectors = 0;
  int miscompares = 0;

  lsb_queue #(.DEPTH_LOG(3), .TAG_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_q1(disp_q1), .disp_q2(disp_q2),
    .disp_v1(disp_v1), .disp_v2(disp_v2), .disp_imm(disp_imm), .disp_tag(disp_tag),
    .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .res_valid(res_valid), .res_tag(res_tag), .res_data(res_data)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required summary");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] op, input logic [4:0] q1, input logic [4:0] q2,
                      input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] imm,
                      input logic [4:0] tag);
    disp_valid = 1'b1; disp_op = op; disp_q1 = q1; disp_q2 = q2;
    disp_v1 = v1; disp_v2 = v2; disp_imm = imm; disp_tag = tag;
    tick;
    disp_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    disp_valid = 1'b1; disp_op = 4'b0010; disp_q1 = 0; disp_q2 = 0; disp_tag = 5'd1;
    disp_v1 = 0; disp_v2 = 0; disp_imm = 0;
    tick; tick;
    disp_valid = 1'b0;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    vectors++; if (mem_we !== 1'b0 || mem_size !== 2'd0) begin miscompares++; $display("FAIL reset_we_size got %b/%0d want 0/0", mem_we, mem_size); end
    vectors++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin miscompares++; $display("FAIL reset_addr_wdata got %h/%h want 0/0", mem_addr, mem_wdata); end
    vectors++; if (res_valid !== 1'b0 || res_tag !== 5'd0 || res_data !== 32'h0) begin miscompares++; $display("FAIL reset_res got %b/%0d/%h want 0/0/0", res_valid, res_tag, res_data); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full got %b want 0", full); end
    rst = 1'b0;
    tick; tick;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_no_entry got mem_req %b want 0", mem_req); end
  endtask

  task automatic test_load_word;
    disp(4'b0010, 5'd0, 5'd0, 32'h100, 32'h0, 32'h4, 5'd3);
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL lw_latency got mem_req %b want 0", mem_req); end
    tick;
    vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h104 || mem_size !== 2'd2) begin
      miscompares++; $display("FAIL lw_req got req=%b we=%b addr=%h size=%0d want 1/0/104/2", mem_req, mem_we, mem_addr, mem_size); end
    tick;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h104) begin miscompares++; $display("FAIL lw_hold got req=%b addr=%h want 1/104", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick;
    mem_ack = 1'b0;
    vectors++; if (res_valid !== 1'b1 || res_tag !== 5'd3 || res_data !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL lw_result got %b/%0d/%h want 1/3/deadbeef", res_valid, res_tag, res_data); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL lw_req_drop got %b want 0", mem_req); end
    tick;
    vectors++; if (res_valid !== 1'b0) begin miscompares++; $display("FAIL lw_pulse_width got %b want 0", res_valid); end
  endtask

  task automatic test_load_ext;
    logic [3:0]  ops  [4] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101};
    logic [31:0] rds  [4] = '{32'h12345680, 32'h00000080, 32'h00008001, 32'hABCD8001};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
    for (int k = 0; k < 4; k++) begin
      disp(ops[k], 5'd0, 5'd0, 32'h400, 32'h0, 32'h0, 5'(k + 4));
      tick;
      vectors++; if (mem_req !== 1'b1 || mem_size !== ops[k][1:0]) begin
        miscompares++; $display("FAIL ext%0d_req got req=%b size=%0d want 1/%0d", k, mem_req, mem_size, ops[k][1:0]); end
      mem_ack = 1'b1; mem_rdata = rds[k];
      tick;
      mem_ack = 1'b0;
      vectors++; if (res_valid !== 1'b1 || res_data !== exps[k]) begin
        miscompares++; $display("FAIL ext%0d_data got %b/%h want 1/%h", k, res_valid, res_data, exps[k]); end
    end
  endtask

  task automatic test_store;
    disp(4'b1010, 5'd0, 5'd7, 32'h200, 32'h0, 32'h10, 5'd5);
    tick; tick;
    vectors++; if (res_valid !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL st_wait_data got res=%b req=%b want 0/0", res_valid, mem_req); end
    cdb_valid = 1'b1; cdb_tag = 5'd7; cdb_data = 32'h55;
    tick;
    cdb_valid = 1'b0;
    tick;
    vectors++; if (res_valid !== 1'b1 || res_tag !== 5'd5 || res_data !== 32'h0) begin
      miscompares++; $display("FAIL st_ready got %b/%0d/%h want 1/5/0", res_valid, res_tag, res_data); end
    tick;
    vectors++; if (res_valid !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL st_no_req got res=%b req=%b want 0/0", res_valid, mem_req); end
    commit_valid = 1'b1; commit_tag = 5'd6;
    tick;
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL st_wrong_commit got req=%b want 0", mem_req); end
    commit_tag = 5'd5;
    tick;
    commit_valid = 1'b0;
    vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h55 || mem_addr !== 32'h210 || mem_size !== 2'd2) begin
      miscompares++; $display("FAIL st_issue got req=%b we=%b wdata=%h addr=%h size=%0d want 1/1/55/210/2", mem_req, mem_we, mem_wdata, mem_addr, mem_size); end
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    vectors++; if (mem_req !== 1'b0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL st_done got req=%b res=%b want 0/0", mem_req, res_valid); end
  endtask

  task automatic test_full_wrap;
    int n;
    logic seen;
    for (int k = 1; k <= 8; k++) begin
      disp(4'b0010, 5'd20, 5'd0, 32'h0, 32'h0, 32'((k - 1) * 4), 5'(k));
      if (k == 7) begin vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL full_at7 got %b want 0", full); end end
    end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_at8 got %b want 1", full); end
    disp(4'b0010, 5'd0, 5'd0, 32'h9000, 32'h0, 32'h0, 5'd30);
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_ignore got %b want 1", full); end
    cdb_valid = 1'b1; cdb_tag = 5'd20; cdb_data = 32'h1000;
    tick;
    cdb_valid = 1'b0;
    tick;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h1000) begin miscompares++; $display("FAIL full_first_req got %b/%h want 1/1000", mem_req, mem_addr); end
    // pop and dispatch together while full
    mem_ack = 1'b1; mem_rdata = 32'h1;
    disp_valid = 1'b1; disp_op = 4'b0010; disp_q1 = 0; disp_q2 = 0;
    disp_v1 = 32'h2000; disp_v2 = 0; disp_imm = 0; disp_tag = 5'd9;
    tick;
    mem_ack = 1'b0; disp_valid = 1'b0;
    vectors++; if (res_valid !== 1'b1 || res_tag !== 5'd1) begin miscompares++; $display("FAIL full_pop1 got %b/%0d want 1/1", res_valid, res_tag); end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL full_pop_disp got %b want 1", full); end
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (mem_req !== 1'b1 && n < 10) begin tick; n++; end
      vectors++; if (mem_req !== 1'b1 || mem_addr !== ((k < 7) ? 32'h1000 + 32'((k + 1) * 4) : 32'h2000)) begin
        miscompares++; $display("FAIL wrap%0d_req got %b/%h", k, mem_req, mem_addr); end
      mem_ack = 1'b1;
      tick;
      mem_ack = 1'b0;
      vectors++; if (res_valid !== 1'b1 || res_tag !== ((k < 7) ? 5'(k + 2) : 5'd9)) begin
        miscompares++; $display("FAIL wrap%0d_tag got %b/%0d want 1/%0d", k, res_valid, res_tag, (k < 7) ? k + 2 : 9); end
      if (k == 0) begin vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL full_clear got %b want 0", full); end end
    end
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin tick; if (mem_req === 1'b1) seen = 1'b1; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL full_dropped_entry got req seen=%b want 0", seen); end
  endtask

  task automatic test_flush;
    logic seen;
    disp(4'b0010, 5'd0, 5'd0, 32'h500, 32'h0, 32'h0, 5'd11);
    disp(4'b0010, 5'd0, 5'd0, 32'h504, 32'h0, 32'h0, 5'd12);
    disp(4'b0010, 5'd0, 5'd0, 32'h508, 32'h0, 32'h0, 5'd13);
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) begin miscompares++; $display("FAIL fl_ld_req got %b/%h want 1/500", mem_req, mem_addr); end
    flush = 1'b1;
    disp(4'b0010, 5'd0, 5'd0, 32'h50C, 32'h0, 32'h0, 5'd14);
    flush = 1'b0;
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL fl_drain_hold got %b want 1", mem_req); end
    mem_ack = 1'b1; mem_rdata = 32'h77;
    tick;
    mem_ack = 1'b0;
    vectors++; if (mem_req !== 1'b0 || res_valid !== 1'b0) begin miscompares++; $display("FAIL fl_drain_ack got req=%b res=%b want 0/0", mem_req, res_valid); end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin tick; if (mem_req === 1'b1 || res_valid === 1'b1) seen = 1'b1; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL fl_entries_cleared got activity=%b want 0", seen); end
    // flush while a committed store is in flight
    disp(4'b1010, 5'd0, 5'd0, 32'h300, 32'hAA, 32'h0, 5'd15);
    disp(4'b0010, 5'd0, 5'd0, 32'h600, 32'h0, 32'h0, 5'd16);
    vectors++; if (res_valid !== 1'b1 || res_tag !== 5'd15) begin miscompares++; $display("FAIL fl_st_ready got %b/%0d want 1/15", res_valid, res_tag); end
    commit_valid = 1'b1; commit_tag = 5'd15;
    tick;
    commit_valid = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    vectors++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'hAA) begin
      miscompares++; $display("FAIL fl_st_keep got req=%b we=%b wdata=%h want 1/1/aa", mem_req, mem_we, mem_wdata); end
    mem_ack = 1'b1;
    tick;
    mem_ack = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin tick; if (mem_req === 1'b1 || res_valid === 1'b1) seen = 1'b1; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL fl_st_load_dropped got activity=%b want 0", seen); end
    // count must be back to zero: eight dispatches fill exactly
    for (int k = 1; k <= 8; k++) begin
      disp(4'b0010, 5'd21, 5'd0, 32'h0, 32'h0, 32'h0, 5'(k));
      if (k == 7) begin vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL fl_count7 got full %b want 0", full); end end
    end
    vectors++; if (full !== 1'b1) begin miscompares++; $display("FAIL fl_count8 got full %b want 1", full); end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL fl_idle_clear got full %b want 0", full); end
  endtask

  task automatic test_bypass;
    cdb_valid = 1'b1; cdb_tag = 5'd9; cdb_data = 32'h4000;
    disp(4'b0010, 5'd9, 5'd0, 32'hBAD0, 32'h0, 32'h8, 5'd17);
    cdb_valid = 1'b0;
    tick;
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h4008) begin miscompares++; $display("FAIL byp_req got %b/%h want 1/4008", mem_req, mem_addr); end
    mem_ack = 1'b1; mem_rdata = 32'h11223344;
    tick;
    mem_ack = 1'b0;
    vectors++; if (res_valid !== 1'b1 || res_tag !== 5'd17 || res_data !== 32'h11223344) begin
      miscompares++; $display("FAIL byp_result got %b/%0d/%h want 1/17/11223344", res_valid, res_tag, res_data); end
  endtask

  task automatic test_reset_mid;
    logic seen;
    disp(4'b0010, 5'd0, 5'd0, 32'h700, 32'h0, 32'h0, 5'd18);
    disp(4'b0010, 5'd0, 5'd0, 32'h704, 32'h0, 32'h0, 5'd19);
    vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL rm_req got %b want 1", mem_req); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    vectors++; if (mem_req !== 1'b0 || mem_addr !== 32'h0 || full !== 1'b0) begin
      miscompares++; $display("FAIL rm_state got req=%b addr=%h full=%b want 0/0/0", mem_req, mem_addr, full); end
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin tick; if (mem_req === 1'b1 || res_valid === 1'b1) seen = 1'b1; end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rm_empty got activity=%b want 0", seen); end
  endtask

  initial begin
    rst = 1'b1; disp_valid = 1'b0; disp_op = 0; disp_q1 = 0; disp_q2 = 0;
    disp_v1 = 0; disp_v2 = 0; disp_imm = 0; disp_tag = 0;
    cdb_valid = 1'b0; cdb_tag = 0; cdb_data = 0;
    commit_valid = 1'b0; commit_tag = 0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = 0;
    test_reset;
    test_load_word;
    test_load_ext;
    test_store;
    test_full_wrap;
    test_flush;
    test_bypass;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
